soc_pwm_dt: RTL and testbench

//  Next-generation SoC PWM controller: CHANNELS independent channels, each comparing a selectable shared timer count against a double-buffered duty value.

---
 rtl/soc_pwm_dt_if.sv | 20 ++
 rtl/soc_pwm_dt.sv | 246 ++++++++++++++++++++++++
 tb/tb_soc_pwm_dt.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/soc_pwm_dt_if.sv
// SoC memory bus: one-cycle request phase, read data returned with rvalid.
// The slave presents rdata/rvalid a fixed number of cycles after a read request.
interface SoC_MemBus;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;

    modport Slave (
        input  req, we, addr, wdata,
        output rdata, rvalid
    );

    modport Master (
        output req, we, addr, wdata,
        input  rdata, rvalid
    );
endinterface

// File: rtl/soc_pwm_dt.sv
// Multi-channel PWM with double-buffered duty, polarity, load lock/irq
// and complementary outputs with programmable dead-time insertion.
module soc_pwm_dt #(
    parameter int BUS_LATENCY = 1,
    parameter int CHANNELS    = 4,
    parameter int TIMER_COUNT = 1,
    parameter int COUNT_WIDTH = 32,
    parameter int DT_WIDTH    = 8
) (
    input  logic                                    clk,
    input  logic                                    res,
    input  logic [TIMER_COUNT-1:0][COUNT_WIDTH-1:0] timer_counts,
    output logic [CHANNELS-1:0]                     pwm_p,
    output logic [CHANNELS-1:0]                     pwm_n,
    output logic [CHANNELS-1:0]                     irq,
    SoC_MemBus.Slave                                mem_bus
);

    localparam logic [3:0]  REG_CTRL  = 4'd0;
    localparam logic [3:0]  REG_VALUE = 4'd1;
    localparam logic [3:0]  REG_NEXT  = 4'd2;
    localparam logic [3:0]  REG_DT    = 4'd3;
    localparam logic [3:0]  REG_STAT  = 4'd4;
    localparam logic [12:0] CTRL_MASK = 13'h1F0F;

    typedef enum logic [1:0] {
        ST_LOW,
        ST_DT_RISE,
        ST_HIGH,
        ST_DT_FALL
    } pwm_st_e;

    function automatic logic [31:0] f_wrval(
        input logic [31:0] old,
        input logic [31:0] d,
        input logic [1:0]  t
    );
        case (t)
            2'd0:    f_wrval = d;
            2'd1:    f_wrval = old | d;
            2'd2:    f_wrval = old & ~d;
            default: f_wrval = old ^ d;
        endcase
    endfunction

    logic [3:0]  w_ch;
    logic [3:0]  w_reg;
    logic [1:0]  w_typ;
    logic        w_wr;
    logic        w_rd;
    logic [31:0] w_rdata;
    logic [31:0] w_ch_rd [CHANNELS];
    logic        w_unused;

    assign w_ch     = mem_bus.addr[11:8];
    assign w_reg    = mem_bus.addr[7:4];
    assign w_typ    = mem_bus.addr[3:2];
    assign w_wr     = mem_bus.req & mem_bus.we;
    assign w_rd     = mem_bus.req & ~mem_bus.we;
    assign w_unused = ^{mem_bus.addr[31:12], mem_bus.addr[1:0]};

    // Out-of-range channels fall through to zero.
    always_comb begin
        w_rdata = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (w_ch == 4'(c)) begin
                w_rdata = w_ch_rd[c];
            end
        end
    end

    logic [BUS_LATENCY-1:0]       r_rv;
    logic [BUS_LATENCY-1:0][31:0] r_rd;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_rv <= '0;
            r_rd <= '0;
        end else begin
            r_rv[0] <= w_rd;
            r_rd[0] <= w_rd ? w_rdata : '0;
            for (int k = 1; k < BUS_LATENCY; k++) begin
                r_rv[k] <= r_rv[k-1];
                r_rd[k] <= r_rd[k-1];
            end
        end
    end

    assign mem_bus.rvalid = r_rv[BUS_LATENCY-1];
    assign mem_bus.rdata  = r_rd[BUS_LATENCY-1];

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [12:0]            r_ctrl;
        logic [COUNT_WIDTH-1:0] r_val;
        logic [COUNT_WIDTH-1:0] r_next;
        logic [COUNT_WIDTH-1:0] w_cnt;
        logic [DT_WIDTH-1:0]    r_dt;
        logic [DT_WIDTH-1:0]    r_dtc;
        logic [DT_WIDTH-1:0]    w_dtc;
        logic                   r_flag;
        logic                   r_irq;
        logic                   r_p;
        logic                   r_n;
        logic [31:0]            w_rdv;
        pwm_st_e                r_st;
        pwm_st_e                w_st;
        logic                   w_sel;
        logic                   w_idx_ok;
        logic                   w_en;
        logic                   w_cmp;
        logic                   w_pol;
        logic                   w_raw;
        logic                   w_load;
        logic                   w_p;
        logic                   w_n;

        assign w_sel = w_wr && (w_ch == 4'(i));
        assign w_en  = r_ctrl[8];
        assign w_pol = r_ctrl[9];
        assign w_cmp = r_ctrl[10];

        always_comb begin
            w_cnt    = '0;
            w_idx_ok = 1'b0;
            for (int t = 0; t < TIMER_COUNT; t++) begin
                if (r_ctrl[3:0] == 4'(t)) begin
                    w_cnt    = timer_counts[t];
                    w_idx_ok = 1'b1;
                end
            end
        end

        assign w_raw  = w_en & w_idx_ok & (w_cnt < r_val);
        assign w_load = w_en & ~r_ctrl[11] & w_idx_ok & (w_cnt == '0);

        always_ff @(posedge clk or negedge res) begin
            if (!res) begin
                r_ctrl <= '0;
                r_val  <= '0;
                r_next <= '0;
                r_dt   <= '0;
                r_flag <= 1'b0;
                r_irq  <= 1'b0;
            end else begin
                if (w_load) begin
                    r_val <= r_next;
                end
                if (w_sel && w_reg == REG_CTRL) begin
                    r_ctrl <= 13'(f_wrval(32'(r_ctrl), mem_bus.wdata, w_typ))
                              & CTRL_MASK;
                end
                if (w_sel && w_reg == REG_NEXT) begin
                    r_next <= COUNT_WIDTH'(f_wrval(32'(r_next), mem_bus.wdata, w_typ));
                end
                if (w_sel && w_reg == REG_DT) begin
                    r_dt <= DT_WIDTH'(f_wrval(32'(r_dt), mem_bus.wdata, w_typ));
                end
                // A load in the same cycle as a clear keeps the flag set.
                if (w_load) begin
                    r_flag <= 1'b1;
                end else if (w_sel && w_reg == REG_STAT && mem_bus.wdata[0]) begin
                    r_flag <= 1'b0;
                end
                r_irq <= r_flag & r_ctrl[12];
            end
        end

        always_comb begin
            w_rdv = '0;
            case (w_reg)
                REG_CTRL:  w_rdv = 32'(r_ctrl);
                REG_VALUE: w_rdv = 32'(r_val);
                REG_NEXT:  w_rdv = 32'(r_next);
                REG_DT:    w_rdv = 32'(r_dt);
                REG_STAT:  w_rdv = {31'd0, r_flag};
                default:   w_rdv = '0;
            endcase
        end

        assign w_ch_rd[i] = w_rdv;

        always_comb begin
            w_st  = r_st;
            w_dtc = r_dtc;
            if (!w_en || !w_cmp) begin
                w_st = ST_LOW;
            end else begin
                unique case (r_st)
                    ST_LOW: begin
                        if (w_raw) begin
                            w_st  = ST_DT_RISE;
                            w_dtc = r_dt;
                        end
                    end
                    ST_DT_RISE: begin
                        if (!w_raw) begin
                            w_st = ST_LOW;
                        end else if (r_dtc == '0) begin
                            w_st = ST_HIGH;
                        end else begin
                            w_dtc = r_dtc - DT_WIDTH'(1);
                        end
                    end
                    ST_HIGH: begin
                        if (!w_raw) begin
                            w_st  = ST_DT_FALL;
                            w_dtc = r_dt;
                        end
                    end
                    ST_DT_FALL: begin
                        if (w_raw) begin
                            w_st = ST_HIGH;
                        end else if (r_dtc == '0) begin
                            w_st = ST_LOW;
                        end else begin
                            w_dtc = r_dtc - DT_WIDTH'(1);
                        end
                    end
                endcase
            end
        end

        // Outputs are decoded from the next state so they register with it.
        assign w_p = w_en & (w_cmp ? (w_st == ST_HIGH) : w_raw);
        assign w_n = w_en & w_cmp & (w_st == ST_LOW);

        always_ff @(posedge clk or negedge res) begin
            if (!res) begin
                r_st  <= ST_LOW;
                r_dtc <= '0;
                r_p   <= 1'b0;
                r_n   <= 1'b0;
            end else begin
                r_st  <= w_st;
                r_dtc <= w_dtc;
                r_p   <= w_p ^ w_pol;
                r_n   <= w_n ^ w_pol;
            end
        end

        assign pwm_p[i] = r_p;
        assign pwm_n[i] = r_n;
        assign irq[i]   = r_irq;
    end

endmodule

// File: tb/tb_soc_pwm_dt.sv
// Directed bench for soc_pwm_dt: duty load, dead-time, lock/irq,
// polarity, bus decode and asynchronous reset.
module tb_soc_pwm_dt;

    localparam int CH = 4;
    localparam int TC = 1;
    localparam int CW = 32;
    localparam int DW = 8;

    localparam logic [3:0] R_CTRL  = 4'd0;
    localparam logic [3:0] R_VALUE = 4'd1;
    localparam logic [3:0] R_NEXT  = 4'd2;
    localparam logic [3:0] R_DT    = 4'd3;
    localparam logic [3:0] R_STAT  = 4'd4;

    logic                  clk = 1'b0;
    logic                  res = 1'b0;
    logic [TC-1:0][CW-1:0] timer_counts;
    logic [CH-1:0]         pwm_p;
    logic [CH-1:0]         pwm_n;
    logic [CH-1:0]         irq;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] cnt = '0;
    logic [31:0] per = 32'd10;
    bit          run = 1'b0;

    SoC_MemBus bus();

    assign timer_counts[0] = cnt;

    soc_pwm_dt #(
        .BUS_LATENCY(1),
        .CHANNELS(CH),
        .TIMER_COUNT(TC),
        .COUNT_WIDTH(CW),
        .DT_WIDTH(DW)
    ) dut (
        .clk(clk),
        .res(res),
        .timer_counts(timer_counts),
        .pwm_p(pwm_p),
        .pwm_n(pwm_n),
        .irq(irq),
        .mem_bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock; the timer advances after the edge has sampled it.
    task automatic step();
        @(posedge clk);
        #1;
        if (run) cnt = (cnt == per - 32'd1) ? '0 : cnt + 32'd1;
    endtask

    task automatic bus_wr(input logic [3:0] ch, input logic [3:0] rg,
                          input logic [1:0] typ, input logic [31:0] d);
        bus.req   = 1'b1;
        bus.we    = 1'b1;
        bus.addr  = {20'd0, ch, rg, typ, 2'b00};
        bus.wdata = d;
        step();
        bus.req   = 1'b0;
        bus.we    = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] ch,
                          input logic [3:0] rg, input logic [31:0] exp);
        int n;
        n        = 0;
        bus.req  = 1'b1;
        bus.we   = 1'b0;
        bus.addr = {20'd0, ch, rg, 4'b0000};
        step();
        bus.req  = 1'b0;
        while (!bus.rvalid && n < 4) begin
            step();
            n++;
        end
        chk({tag, "_rvalid"}, 32'(bus.rvalid), 32'd1);
        chk(tag, bus.rdata, exp);
    endtask

    task automatic wait_count(input logic [31:0] v);
        int n;
        n = 0;
        while (cnt != v && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) chk("wait_count", cnt, v);
    endtask

    initial begin
        logic [31:0] c;
        int          n;

        bus.req   = 1'b0;
        bus.we    = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;

        // reset state
        repeat (3) step();
        chk("rst_p", 32'(pwm_p), 32'd0);
        chk("rst_n", 32'(pwm_n), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        @(negedge clk);
        res = 1'b1;
        step();
        rd_chk("rst_ctrl0", 4'd0, R_CTRL, 32'd0);
        rd_chk("rst_next1", 4'd1, R_NEXT, 32'd0);

        // 1: basic duty 3/10 on ch0
        cnt = 32'd5;
        bus_wr(4'd0, R_NEXT, 2'd0, 32'd3);
        bus_wr(4'd0, R_CTRL, 2'd0, 32'h100);
        cnt = 32'd9;
        per = 32'd10;
        run = 1'b1;
        repeat (12) step();
        n = 0;
        for (int i = 0; i < 10; i++) begin
            c = cnt;
            step();
            chk("t1_p", 32'(pwm_p[0]), 32'(c < 32'd3));
            chk("t1_irq", 32'(irq[0]), 32'd0);
            n += int'(pwm_p[0]);
        end
        chk("t1_highs", 32'(n), 32'd3);
        rd_chk("t1_value", 4'd0, R_VALUE, 32'd3);
        rd_chk("t1_flag", 4'd0, R_STAT, 32'd1);

        // 2: complementary ch1, duty 5/20, dead-time 2 then 0
        wait_count(32'd5);
        run = 1'b0;
        per = 32'd20;
        bus_wr(4'd1, R_NEXT, 2'd0, 32'd5);
        bus_wr(4'd1, R_DT, 2'd0, 32'd2);
        bus_wr(4'd1, R_CTRL, 2'd0, 32'h500);
        cnt = 32'd10;
        run = 1'b1;
        repeat (25) step();
        for (int i = 0; i < 20; i++) begin
            c = cnt;
            step();
            chk("t2_p_dt2", 32'(pwm_p[1]), 32'(c == 32'd3 || c == 32'd4));
            chk("t2_n_dt2", 32'(pwm_n[1]), 32'(c >= 32'd8));
            chk("t2_excl", 32'(pwm_p[1] & pwm_n[1]), 32'd0);
        end
        wait_count(32'd10);
        run = 1'b0;
        bus_wr(4'd1, R_DT, 2'd0, 32'd0);
        step();
        run = 1'b1;
        for (int i = 0; i < 20; i++) begin
            c = cnt;
            step();
            chk("t2_p_dt0", 32'(pwm_p[1]), 32'(c >= 32'd1 && c <= 32'd4));
            chk("t2_n_dt0", 32'(pwm_n[1]), 32'(c >= 32'd6));
        end

        // 3: NEXT written in the load cycle
        wait_count(32'd5);
        run = 1'b0;
        per = 32'd10;
        bus_wr(4'd0, R_NEXT, 2'd0, 32'd4);
        run = 1'b1;
        wait_count(32'd0);
        bus_wr(4'd0, R_NEXT, 2'd0, 32'd6);
        rd_chk("t3_value_old", 4'd0, R_VALUE, 32'd4);
        rd_chk("t3_next", 4'd0, R_NEXT, 32'd6);
        wait_count(32'd0);
        step();
        rd_chk("t3_value_new", 4'd0, R_VALUE, 32'd6);

        // 4: load lock and irq
        bus_wr(4'd0, R_CTRL, 2'd0, 32'h1900);
        bus_wr(4'd0, R_STAT, 2'd0, 32'd1);
        bus_wr(4'd0, R_NEXT, 2'd0, 32'd7);
        repeat (35) step();
        rd_chk("t4_locked_value", 4'd0, R_VALUE, 32'd6);
        rd_chk("t4_locked_flag", 4'd0, R_STAT, 32'd0);
        chk("t4_locked_irq", 32'(irq[0]), 32'd0);
        bus_wr(4'd0, R_CTRL, 2'd2, 32'h800);
        rd_chk("t4_ctrl", 4'd0, R_CTRL, 32'h1100);
        wait_count(32'd0);
        step();
        step();
        chk("t4_irq", 32'(irq[0]), 32'd1);
        rd_chk("t4_value", 4'd0, R_VALUE, 32'd7);
        rd_chk("t4_flag", 4'd0, R_STAT, 32'd1);

        // 5: polarity, bus access types, idx out of range, bad decode
        bus_wr(4'd2, R_CTRL, 2'd0, 32'hFFFF_E2F0);
        step();
        chk("t5_pol_p", 32'(pwm_p[2]), 32'd1);
        chk("t5_pol_n", 32'(pwm_n[2]), 32'd1);
        rd_chk("t5_ctrl_mask", 4'd2, R_CTRL, 32'h200);
        bus_wr(4'd2, R_NEXT, 2'd0, 32'hF0);
        bus_wr(4'd2, R_NEXT, 2'd1, 32'h0F);
        rd_chk("t5_set", 4'd2, R_NEXT, 32'hFF);
        bus_wr(4'd2, R_NEXT, 2'd2, 32'h3C);
        rd_chk("t5_clear", 4'd2, R_NEXT, 32'hC3);
        bus_wr(4'd2, R_NEXT, 2'd3, 32'hFF);
        rd_chk("t5_toggle", 4'd2, R_NEXT, 32'h3C);
        bus_wr(4'd2, R_VALUE, 2'd0, 32'h77);
        rd_chk("t5_value_ro", 4'd2, R_VALUE, 32'd0);
        bus_wr(4'd2, R_DT, 2'd0, 32'h1FF);
        rd_chk("t5_dt_width", 4'd2, R_DT, 32'hFF);
        bus_wr(4'd3, R_NEXT, 2'd0, 32'hFFFF);
        bus_wr(4'd3, R_CTRL, 2'd0, 32'h100);
        wait_count(32'd0);
        step();
        step();
        chk("t5_full_p", 32'(pwm_p[3]), 32'd1);
        chk("t5_full_n", 32'(pwm_n[3]), 32'd0);
        bus_wr(4'd3, R_CTRL, 2'd0, 32'h101);
        bus_wr(4'd3, R_NEXT, 2'd0, 32'h10);
        step();
        chk("t5_badidx_p", 32'(pwm_p[3]), 32'd0);
        repeat (12) step();
        chk("t5_badidx_p2", 32'(pwm_p[3]), 32'd0);
        rd_chk("t5_badidx_value", 4'd3, R_VALUE, 32'hFFFF);
        bus_wr(4'd4, R_NEXT, 2'd0, 32'h55);
        rd_chk("t5_bad_ch", 4'd4, R_NEXT, 32'd0);
        rd_chk("t5_bad_reg", 4'd0, 4'd5, 32'd0);

        // 6: asynchronous reset while ch1 is HIGH
        n = 0;
        while (!pwm_p[1] && n < 50) begin
            step();
            n++;
        end
        chk("t6_reach_high", 32'(pwm_p[1]), 32'd1);
        #2;
        res = 1'b0;
        #1;
        chk("t6_async_p", 32'(pwm_p), 32'd0);
        chk("t6_async_n", 32'(pwm_n), 32'd0);
        chk("t6_async_irq", 32'(irq), 32'd0);
        step();
        step();
        @(negedge clk);
        res = 1'b1;
        repeat (3) step();
        chk("t6_rel_p", 32'(pwm_p), 32'd0);
        chk("t6_rel_n", 32'(pwm_n), 32'd0);
        chk("t6_rel_irq", 32'(irq), 32'd0);
        for (int ch = 0; ch < CH; ch++) begin
            for (int r = 0; r < 5; r++) begin
                rd_chk($sformatf("t6_ch%0d_r%0d", ch, r), 4'(ch), 4'(r), 32'd0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
